wb_writer: RTL

WB_WRITER -- requirements
Module: wb_writer

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 51 +++++
 rtl/wb_writer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: default widths, queue depth
// and the layout of one queued register-file write.
package wb_pkg;

    localparam int BIT_SIZE_DEFAULT = 32;
    localparam int DEPTH_DEFAULT    = 4;
    localparam int ADDR_W           = 5;

    // One pending register-file write at the default data width.
    typedef struct packed {
        logic [ADDR_W-1:0]           addr;
        logic [BIT_SIZE_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue storage: dual-push (slot a then slot b), single-pop FIFO.
// The caller guarantees that pushes never exceed the free space after the
// same-cycle pop, so no overflow protection lives here.
module wb_fifo #(
    parameter  int W     = 37,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_a,
    input  logic [W-1:0]  data_a,
    input  logic          push_b,
    input  logic [W-1:0]  data_b,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage writes; slot b always lands directly after slot a, and the
    // pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push_a) begin
            mem[wr_ptr] <= data_a;
        end
        if (push_b) begin
            mem[wr_ptr + PW'(1)] <= data_b;
        end
    end

    // Pointer and occupancy bookkeeping; count tells full apart from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_writer.sv
// Writeback arbiter: merges load and ALU results into one register-file
// write port through a small queue. Mem is always ordered ahead of ALU, and
// when space runs out the ALU request is the one dropped (sticky overflow).
// Optional macro WB_BYPASS_EN lets the first request of a cycle go straight
// to the write port when the queue is empty.
module wb_writer
    import wb_pkg::*;
#(
    parameter  int bit_size = BIT_SIZE_DEFAULT,
    parameter  int DEPTH    = DEPTH_DEFAULT,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [bit_size-1:0] mem_data,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [bit_size-1:0] alu_data,
    output logic                stall,
    output logic                overflow,
    output logic [CW-1:0]       count,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   Write_addr,
    output logic [bit_size-1:0] Write_data
);

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [bit_size-1:0] data;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t        mem_entry;
    entry_t        alu_entry;
    entry_t        data_a;
    entry_t        data_b;
    entry_t        head;
    entry_t        byp_entry;
    logic          byp_valid;
    logic          mem_ok;
    logic          alu_ok;
    logic          mem_q;
    logic          alu_q;
    logic          mem_fit;
    logic          alu_fit;
    logic          drop;
    logic          pop;
    logic          push_a;
    logic          push_b;
    logic [CW:0]   free;

    // Arbitration: filter r0 writes, optionally bypass, then fit requests
    // into the space left after this cycle's dequeue, mem first.
    always_comb begin
        mem_entry = '{addr: mem_addr, data: mem_data};
        alu_entry = '{addr: alu_addr, data: alu_data};
        mem_ok    = !rst && mem_valid && (mem_addr != '0);
        alu_ok    = !rst && alu_valid && (alu_addr != '0);
        byp_valid = 1'b0;
        byp_entry = '0;
        mem_q     = mem_ok;
        alu_q     = alu_ok;
`ifdef WB_BYPASS_EN
        if (count == '0) begin
            if (mem_ok) begin
                byp_valid = 1'b1;
                byp_entry = mem_entry;
                mem_q     = 1'b0;
            end else if (alu_ok) begin
                byp_valid = 1'b1;
                byp_entry = alu_entry;
                alu_q     = 1'b0;
            end
        end
`endif
        pop     = (count != '0);
        free    = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
        mem_fit = mem_q && (free >= (CW+1)'(1));
        alu_fit = alu_q && (free >= ((CW+1)'(1) + (CW+1)'(mem_fit)));
        drop    = (mem_q && !mem_fit) || (alu_q && !alu_fit);
        push_a  = mem_fit || alu_fit;
        push_b  = mem_fit && alu_fit;
        data_a  = mem_fit ? mem_entry : alu_entry;
        data_b  = alu_entry;
    end

    wb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_a (push_a),
        .data_a (data_a),
        .push_b (push_b),
        .data_b (data_b),
        .pop    (pop),
        .head   (head),
        .count  (count)
    );

    // Write port: queue head has priority; bypass only ever fires when empty.
    always_comb begin
        RegWrite   = 1'b0;
        Write_addr = '0;
        Write_data = '0;
        if (count != '0) begin
            RegWrite   = 1'b1;
            Write_addr = head.addr;
            Write_data = head.data;
        end else if (byp_valid) begin
            RegWrite   = 1'b1;
            Write_addr = byp_entry.addr;
            Write_data = byp_entry.data;
        end
    end

    assign stall = (count > CW'(DEPTH - 2));

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

endmodule
